md_issue_ctrl: RTL and testbench

//  E-stage issue/stall controller sitting directly upstream of the multiply/divide unit.
//  - Gates the E-stage mul/div start and HI/LO write strobes against the interrupt/exception request.
//  - Keeps a cycle-exact shadow of the unit's busy countdown.
//  - Raises the D-stage stall for any mul/div-class instruction (mult/multu/div/divu/mfhi/mflo/mthi/mtlo)

---
 rtl/md_issue_ctrl.sv | 118 +++++++++++
 tb/tb_md_issue_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// E-stage issue/stall controller for the multiply/divide unit: gates start/write strobes,
// shadows the unit's busy countdown, stalls D for mul/div-class instructions and counts stalls.
module md_issue_ctrl #(
    parameter int          MUL_LAT  = 5,
    parameter int          DIV_LAT  = 10,
    parameter int          CNT_W    = 32,
    parameter int          CHECK_EN = 1,
    parameter logic [2:0]  SEL_MUL  = 3'd1,
    parameter logic [2:0]  SEL_MULU = 3'd2,
    parameter logic [2:0]  SEL_DIV  = 3'd3,
    parameter logic [2:0]  SEL_DIVU = 3'd4,
    localparam int         CW       = ($clog2(DIV_LAT + 1) > 4) ? $clog2(DIV_LAT + 1) : 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req,
    input  logic             i_d_is_md,
    input  logic             i_e_start,
    input  logic             i_e_we,
    input  logic [2:0]       i_e_sel,
    input  logic             i_md_busy,
    output logic             o_md_start,
    output logic             o_md_we,
    output logic             o_stall_d,
    output logic             o_busy_pred,
    output logic             o_mismatch,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CW-1:0]    o_cnt,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_t;

    localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT);

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_next;
    logic               r_mismatch;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_md_start;
    logic               w_md_we;
    logic               w_busy_pred;
    logic               w_stall_d;
    logic               w_sel_mul;
    logic               w_sel_div;

    // Strobes are also held low during reset so every output is 0 while rst_n is low.
    assign w_md_start  = i_rst_n & i_e_start & ~i_req;
    assign w_md_we     = i_rst_n & i_e_we & ~i_req;
    assign w_busy_pred = (r_cnt != '0);
    assign w_stall_d   = i_d_is_md & (w_busy_pred | w_md_start);
    assign w_sel_mul   = (i_e_sel == SEL_MUL) || (i_e_sel == SEL_MULU);
    assign w_sel_div   = (i_e_sel == SEL_DIV) || (i_e_sel == SEL_DIVU);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Same priority as the unit: write clears, then issue (re)loads, then countdown.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (w_md_we) begin
            w_cnt_next   = '0;
            w_state_next = IDLE;
        end else if (w_md_start && w_sel_mul) begin
            w_cnt_next   = MUL_LD;
            w_state_next = MUL_RUN;
        end else if (w_md_start && w_sel_div) begin
            w_cnt_next   = DIV_LD;
            w_state_next = DIV_RUN;
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                w_state_next = IDLE;
            end
        end
    end

    always_comb begin
        o_state     = r_state;
        o_cnt       = r_cnt;
        o_md_start  = w_md_start;
        o_md_we     = w_md_we;
        o_busy_pred = w_busy_pred;
        o_stall_d   = w_stall_d;
        o_mismatch  = r_mismatch;
        o_stall_cnt = r_stall_cnt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mismatch  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if ((CHECK_EN != 0) && (w_busy_pred != i_md_busy)) begin
                r_mismatch <= 1'b1;
            end
            if (w_stall_d && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl; a second instance with a 4-bit stall counter checks saturation.
module tb_md_issue_ctrl;

    localparam logic [2:0] SEL_MUL  = 3'd1;
    localparam logic [2:0] SEL_DIV  = 3'd3;
    localparam logic [2:0] SEL_MFHI = 3'd5;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MUL   = 2'd1;
    localparam logic [1:0] ST_DIV   = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        d_is_md = 1'b0;
    logic        e_start = 1'b0;
    logic        e_we = 1'b0;
    logic [2:0]  e_sel = 3'd0;
    logic        md_busy = 1'b0;

    logic        md_start, md_we, stall_d, busy_pred, mismatch;
    logic [31:0] stall_cnt;
    logic [3:0]  cnt;
    logic [1:0]  state;

    logic        s_md_start, s_md_we, s_stall_d, s_busy_pred, s_mismatch;
    logic [3:0]  s_stall_cnt;
    logic [3:0]  s_cnt;
    logic [1:0]  s_state;

    int checks = 0;
    int failures = 0;
    int stalls;

    always #5 clk = ~clk;

    md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(32), .CHECK_EN(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_d_is_md(d_is_md),
        .i_e_start(e_start), .i_e_we(e_we), .i_e_sel(e_sel), .i_md_busy(md_busy),
        .o_md_start(md_start), .o_md_we(md_we), .o_stall_d(stall_d),
        .o_busy_pred(busy_pred), .o_mismatch(mismatch), .o_stall_cnt(stall_cnt),
        .o_cnt(cnt), .o_state(state)
    );

    md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4), .CHECK_EN(1)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_d_is_md(d_is_md),
        .i_e_start(e_start), .i_e_we(e_we), .i_e_sel(e_sel), .i_md_busy(md_busy),
        .o_md_start(s_md_start), .o_md_we(s_md_we), .o_stall_d(s_stall_d),
        .o_busy_pred(s_busy_pred), .o_mismatch(s_mismatch), .o_stall_cnt(s_stall_cnt),
        .o_cnt(s_cnt), .o_state(s_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 1'b0; d_is_md = 1'b0; e_start = 1'b0; e_we = 1'b0; e_sel = 3'd0; md_busy = 1'b0;
    endtask

    initial begin
        // Reset state, applied without any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_state", 32'(state), 32'(ST_IDLE));
        chk("rst_busy", 32'(busy_pred), 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: mult issue, D holds a mul/div-class instruction
        e_start = 1'b1; e_sel = SEL_MUL; d_is_md = 1'b1; #1;
        chk("t1_md_start", 32'(md_start), 1);
        chk("t1_stall_issue", 32'(stall_d), 1);
        chk("t1_busy_issue", 32'(busy_pred), 0);
        tick();
        e_start = 1'b0; e_sel = 3'd0;
        for (int k = 1; k <= 5; k++) begin
            md_busy = 1'b1; #1;
            chk($sformatf("t1_cnt_%0d", k), 32'(cnt), 32'(6 - k));
            chk($sformatf("t1_busy_%0d", k), 32'(busy_pred), 1);
            chk($sformatf("t1_stall_%0d", k), 32'(stall_d), 1);
            chk($sformatf("t1_state_%0d", k), 32'(state), 32'(ST_MUL));
            tick();
        end
        md_busy = 1'b0; #1;
        chk("t1_busy_end", 32'(busy_pred), 0);
        chk("t1_stall_end", 32'(stall_d), 0);
        chk("t1_stall_cnt", stall_cnt, 6);
        chk("t1_state_end", 32'(state), 32'(ST_IDLE));
        chk("t1_mismatch", 32'(mismatch), 0);
        tick();

        // 2: div issue, mflo waits in D
        e_start = 1'b1; e_sel = SEL_DIV; d_is_md = 1'b1;
        stalls = 0;
        for (int k = 0; k <= 11; k++) begin
            md_busy = (k >= 1 && k <= 10); #1;
            if (stall_d) stalls++;
            if (k == 11) chk("t2_release", 32'(stall_d), 0);
            tick();
            e_start = 1'b0; e_sel = 3'd0;
        end
        chk("t2_stall_cycles", 32'(stalls), 11);
        chk("t2_stall_cnt", stall_cnt, 17);
        chk("t2_mismatch", 32'(mismatch), 0);

        // 3: issue cancelled by req
        idle_inputs();
        e_start = 1'b1; e_sel = SEL_MUL; d_is_md = 1'b1; e_we = 1'b1; req = 1'b1; #1;
        chk("t3_md_start", 32'(md_start), 0);
        chk("t3_md_we", 32'(md_we), 0);
        chk("t3_stall", 32'(stall_d), 0);
        tick();
        idle_inputs(); #1;
        chk("t3_cnt", 32'(cnt), 0);
        chk("t3_busy", 32'(busy_pred), 0);
        tick();

        // 4: mthi at cnt=4 clears a running div
        e_start = 1'b1; e_sel = SEL_DIV;
        tick();
        e_start = 1'b0; e_sel = 3'd0; md_busy = 1'b1;
        for (int k = 1; k < 7; k++) tick();
        #1;
        chk("t4_cnt4", 32'(cnt), 4);
        chk("t4_state_div", 32'(state), 32'(ST_DIV));
        e_we = 1'b1; #1;
        chk("t4_md_we", 32'(md_we), 1);
        tick();
        e_we = 1'b0; md_busy = 1'b0; #1;
        chk("t4_cnt0", 32'(cnt), 0);
        chk("t4_busy", 32'(busy_pred), 0);
        chk("t4_state_idle", 32'(state), 32'(ST_IDLE));
        tick();

        // 5: reset in the middle of a div at cnt=7
        e_start = 1'b1; e_sel = SEL_DIV;
        tick();
        e_start = 1'b0; e_sel = 3'd0; md_busy = 1'b1;
        tick(); tick(); tick();
        #1;
        chk("t5_cnt7", 32'(cnt), 7);
        e_start = 1'b1; e_we = 1'b1; d_is_md = 1'b1; #1;
        rst_n = 1'b0; #1;
        chk("t5_rst_cnt", 32'(cnt), 0);
        chk("t5_rst_busy", 32'(busy_pred), 0);
        chk("t5_rst_md_start", 32'(md_start), 0);
        chk("t5_rst_md_we", 32'(md_we), 0);
        chk("t5_rst_stall", 32'(stall_d), 0);
        chk("t5_rst_stall_cnt", stall_cnt, 0);
        chk("t5_rst_state", 32'(state), 32'(ST_IDLE));
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("t5_no_resume_cnt", 32'(cnt), 0);
        chk("t5_no_resume_busy", 32'(busy_pred), 0);

        // 6: unit busy forced low against the shadow -> sticky mismatch
        e_start = 1'b1; e_sel = SEL_MUL;
        tick();
        e_start = 1'b0; e_sel = 3'd0; md_busy = 1'b0; #1;
        chk("t6_busy_pred", 32'(busy_pred), 1);
        chk("t6_mismatch_before", 32'(mismatch), 0);
        tick();
        md_busy = 1'b1; #1;
        chk("t6_mismatch_set", 32'(mismatch), 1);
        for (int k = 0; k < 6; k++) begin
            md_busy = (cnt != 0);
            tick();
        end
        chk("t6_mismatch_sticky", 32'(mismatch), 1);
        rst_n = 1'b0; #1;
        chk("t6_mismatch_rst", 32'(mismatch), 0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();

        // 6b: stall counter saturation (unloaded select code still stalls via md_start)
        d_is_md = 1'b1; e_start = 1'b1; e_sel = SEL_MFHI;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) chk("t6_sat_14", 32'(s_stall_cnt), 14);
            if (k == 15) chk("t6_sat_15", 32'(s_stall_cnt), 15);
        end
        chk("t6_sat_hold", 32'(s_stall_cnt), 15);
        chk("t6_wide_cnt", stall_cnt, 20);
        chk("t6_noload_cnt", 32'(cnt), 0);
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
